// File: rtl/dcache_data_mbist.sv
// March C- self-test controller for the 2048x32 byte-masked D-cache data array.
// Owns the RW0 port while testing; otherwise passes core requests straight through.
module dcache_data_mbist #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,
  input  logic              io_req_en,
  input  logic              io_req_wmode,
  input  logic [MASK_W-1:0] io_req_wmask,
  output logic              io_req_ready,
  output logic [DATA_W-1:0] io_resp_rdata,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
  output logic              RW0_clk,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]        elem, elem_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              phase, phase_n;

  logic              rd_vld, rd_vld_n;
  logic              rd_ones, rd_ones_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic [2:0]        rd_elem, rd_elem_n;

  logic              fail, fail_n;
  logic [ADDR_W-1:0] fail_addr, fail_addr_n;
  logic [2:0]        fail_elem, fail_elem_n;

  logic down;
  logic two_op;
  logic op_rd;
  logic op_ones;
  logic last_op;
  logic addr_end;
  logic mismatch;
  logic own;
  logic eng_en;
  logic eng_we;

  always_comb begin
    down   = 1'b0;
    two_op = 1'b0;
    unique case (1'b1)
      (elem == 3'd0): begin
        down   = 1'b0;
        two_op = 1'b0;
      end
      (elem == 3'd1),
      (elem == 3'd2): begin
        down   = 1'b0;
        two_op = 1'b1;
      end
      (elem == 3'd3),
      (elem == 3'd4): begin
        down   = 1'b1;
        two_op = 1'b1;
      end
      default: begin
        down   = 1'b1;
        two_op = 1'b0;
      end
    endcase
  end

  // E0 is the only write-first element; odd elements write ones, even read ones.
  assign op_rd    = (elem != 3'd0) && !phase;
  assign op_ones  = op_rd ? ~elem[0] : elem[0];
  assign last_op  = phase || !two_op;
  assign addr_end = down ? (addr == '0) : (addr == '1);
  assign mismatch = rd_vld && (RW0_rdata != {DATA_W{rd_ones}});

  always_comb begin
    state_n     = state;
    elem_n      = elem;
    addr_n      = addr;
    phase_n     = phase;
    rd_vld_n    = 1'b0;
    rd_ones_n   = rd_ones;
    rd_addr_n   = rd_addr;
    rd_elem_n   = rd_elem;
    fail_n      = fail;
    fail_addr_n = fail_addr;
    fail_elem_n = fail_elem;
    eng_en      = 1'b0;
    eng_we      = 1'b0;
    unique case (state)
      IDLE,
      DONE: begin
        if (bist_start) begin
          state_n     = RUN;
          elem_n      = '0;
          addr_n      = '0;
          phase_n     = 1'b0;
          fail_n      = 1'b0;
          fail_addr_n = '0;
          fail_elem_n = '0;
        end
      end
      RUN: begin
        eng_en = 1'b1;
        eng_we = !op_rd;
        if (op_rd) begin
          rd_vld_n  = 1'b1;
          rd_ones_n = op_ones;
          rd_addr_n = addr;
          rd_elem_n = elem;
        end
        if (mismatch) begin
          rd_vld_n    = 1'b0;
          fail_n      = 1'b1;
          fail_addr_n = rd_addr;
          fail_elem_n = rd_elem;
          state_n     = DONE;
        end else if (last_op && addr_end) begin
          if (elem == 3'd5) begin
            state_n = FLUSH;
          end else begin
            elem_n  = elem + 3'd1;
            addr_n  = (elem >= 3'd2) ? '1 : '0;
            phase_n = 1'b0;
          end
        end else if (last_op) begin
          addr_n  = down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
          phase_n = 1'b0;
        end else begin
          phase_n = 1'b1;
        end
      end
      FLUSH: begin
        if (mismatch) begin
          fail_n      = 1'b1;
          fail_addr_n = rd_addr;
          fail_elem_n = rd_elem;
        end
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      elem      <= '0;
      addr      <= '0;
      phase     <= 1'b0;
      rd_vld    <= 1'b0;
      rd_ones   <= 1'b0;
      rd_addr   <= '0;
      rd_elem   <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      elem      <= elem_n;
      addr      <= addr_n;
      phase     <= phase_n;
      rd_vld    <= rd_vld_n;
      rd_ones   <= rd_ones_n;
      rd_addr   <= rd_addr_n;
      rd_elem   <= rd_elem_n;
      fail      <= fail_n;
      fail_addr <= fail_addr_n;
      fail_elem <= fail_elem_n;
    end
  end

  assign own = (state == RUN) || (state == FLUSH);

  assign io_req_ready   = !own;
  assign io_resp_rdata  = RW0_rdata;
  assign bist_busy      = own;
  assign bist_done      = (state == DONE);
  assign bist_fail      = fail;
  assign bist_fail_addr = fail_addr;
  assign bist_fail_elem = fail_elem;

  assign RW0_clk   = clock;
  assign RW0_addr  = own ? addr : io_req_addr;
  assign RW0_wdata = own ? {DATA_W{op_ones}} : io_req_wdata;
  assign RW0_en    = own ? eng_en : io_req_en;
  assign RW0_wmode = own ? eng_we : io_req_wmode;
  assign RW0_wmask = own ? {MASK_W{eng_we}} : io_req_wmask;

endmodule
